ifetch_data_stage: RTL

Second instruction-fetch stage. It sits directly downstream of the ifetch tag stage and consumes its {pc, warp_idx} bus plus the L1 icache tag/valid read launched there. It does the way compare, detects hit / miss / near-miss, and issues the data-array read on a hit. Misses are queued toward the L2 interface, and the miss/near-miss status is fed back to the tag stage so it can roll back the PC and put the warp to sleep.

---
 rtl/ifetch_data_stage_if.sv | 12 +
 rtl/ifetch_data_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_data_stage_if.sv
// Generic valid/allowin pipeline handshake with a payload bus, used on both
// sides of the ifetch data stage (tag stage -> data stage -> decode).
interface ifetch_data_stage_if #(
    parameter int BUS_W = 34
);
    logic             valid;
    logic [BUS_W-1:0] bus;
    logic             allowin;

    modport master (output valid, output bus, input allowin);
    modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/ifetch_data_stage.sv
// Second ifetch stage: icache way compare, hit/miss/near-miss detection, data-array
// read issue and an L2 miss FIFO. Define IFD_PERF_COUNTER_EN to add hit/miss counters.

module ifetch_data_stage_chk #(
    parameter int WAYS = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            i_valid,
    input logic [WAYS-1:0] i_hit_vec,
    input logic            i_cache_miss,
    input logic            i_near_miss
);
    ap_single_way_hit: assert property (@(posedge clk) disable iff (!rst_n)
        i_valid |-> $onehot0(i_hit_vec));

    ap_miss_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_cache_miss && i_near_miss));
endmodule

module ifetch_data_stage #(
    parameter int ADDR_WIDTH            = 32,
    parameter int NUM_WARP_PER_CORE     = 4,
    parameter int L1_CACHE_NUM_WAYS     = 4,
    parameter int L1_CACHE_NUM_SETS     = 64,
    parameter int CACHE_LINE_BYTE_WIDTH = 64,
    parameter int MISS_FIFO_DEPTH       = 4,
    localparam int NUM_WARP_PER_CORE_LOG = $clog2(NUM_WARP_PER_CORE),
    localparam int WAYS_LOG              = $clog2(L1_CACHE_NUM_WAYS),
    localparam int L1_CACHE_NUM_SETS_LOG = $clog2(L1_CACHE_NUM_SETS),
    localparam int LINE_LOG              = $clog2(CACHE_LINE_BYTE_WIDTH),
    localparam int TAG_WIDTH             = ADDR_WIDTH - L1_CACHE_NUM_SETS_LOG - LINE_LOG,
    localparam int DADDR_W               = L1_CACHE_NUM_SETS_LOG + WAYS_LOG + LINE_LOG - 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    ifetch_data_stage_if.slave                     ift_if,
    input  logic [L1_CACHE_NUM_WAYS*TAG_WIDTH-1:0] i_icache_tag_rdata,
    input  logic [L1_CACHE_NUM_WAYS-1:0]           i_icache_tag_valid,
    input  logic                                   i_l2i_fill_en,
    input  logic [L1_CACHE_NUM_SETS_LOG-1:0]       i_l2i_fill_set_idx,
    input  logic [TAG_WIDTH-1:0]                   i_l2i_fill_tag,
    ifetch_data_stage_if.master                    id_if,
    output logic                                   o_ifd_to_icache_data_en,
    output logic [DADDR_W-1:0]                     o_ifd_to_icache_data_addr,
    output logic                                   o_ifd_cache_miss,
    output logic                                   o_ifd_near_miss,
    output logic [NUM_WARP_PER_CORE_LOG-1:0]       o_ifd_cache_miss_warp_idx,
    output logic                                   o_ifd_to_l2i_miss_valid,
    output logic [ADDR_WIDTH-1:0]                  o_ifd_to_l2i_miss_addr,
    output logic [NUM_WARP_PER_CORE_LOG-1:0]       o_ifd_to_l2i_miss_warp_idx,
    input  logic                                   i_l2i_miss_ready,
    input  logic                                   i_wb_rollback_en,
    input  logic [NUM_WARP_PER_CORE_LOG-1:0]       i_wb_rollback_warp_idx
`ifdef IFD_PERF_COUNTER_EN
    ,
    output logic [31:0]                            o_perf_hit_cnt,
    output logic [31:0]                            o_perf_miss_cnt
`endif
);
    localparam int PTR_W = $clog2(MISS_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                                   r_ifd_valid;
    logic [ADDR_WIDTH-1:0]                  r_pc;
    logic [NUM_WARP_PER_CORE_LOG-1:0]       r_warp_idx;
    logic [L1_CACHE_NUM_WAYS*TAG_WIDTH-1:0] r_tag_rdata;
    logic [L1_CACHE_NUM_WAYS-1:0]           r_tag_valid;

    logic [ADDR_WIDTH-1:0]            r_fifo_addr [MISS_FIFO_DEPTH];
    logic [NUM_WARP_PER_CORE_LOG-1:0] r_fifo_warp [MISS_FIFO_DEPTH];
    logic [PTR_W-1:0]                 r_wr_ptr;
    logic [PTR_W-1:0]                 r_rd_ptr;
    logic [CNT_W-1:0]                 r_count;

    logic                             w_allowin;
    logic [TAG_WIDTH-1:0]             w_pc_tag;
    logic [L1_CACHE_NUM_SETS_LOG-1:0] w_set;
    logic [L1_CACHE_NUM_WAYS-1:0]     w_hit_vec;
    logic [WAYS_LOG-1:0]              w_hit_way;
    logic                             w_hit;
    logic                             w_retire;
    logic                             w_eval;
    logic                             w_fill_match;
    logic                             w_fifo_valid;
    logic                             w_pop;
    logic                             w_fifo_block;
    logic                             w_push;
    logic                             w_id_valid;
    logic [ADDR_WIDTH+NUM_WARP_PER_CORE_LOG+WAYS_LOG-1:0] w_id_bus;
    logic                             w_data_en;
    logic [DADDR_W-1:0]               w_data_addr;
    logic                             w_cache_miss;
    logic                             w_near_miss;
    logic [NUM_WARP_PER_CORE_LOG-1:0] w_miss_warp;

    assign w_allowin    = ~r_ifd_valid | id_if.allowin;
    assign w_pc_tag     = r_pc[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_set        = r_pc[LINE_LOG +: L1_CACHE_NUM_SETS_LOG];
    assign w_retire     = r_ifd_valid & id_if.allowin;
    assign w_eval       = w_retire & ~(i_wb_rollback_en & (i_wb_rollback_warp_idx == r_warp_idx));
    assign w_fill_match = i_l2i_fill_en & (i_l2i_fill_set_idx == w_set) & (i_l2i_fill_tag == w_pc_tag);
    assign w_fifo_valid = (r_count != {CNT_W{1'b0}});
    assign w_pop        = w_fifo_valid & i_l2i_miss_ready;
    assign w_fifo_block = (r_count == CNT_W'(MISS_FIFO_DEPTH)) & ~w_pop;
    assign w_push       = w_cache_miss;

    // Entry register; tags are captured with the entry so a decode stall holds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifd_valid <= 1'b0;
            r_pc        <= '0;
            r_warp_idx  <= '0;
            r_tag_rdata <= '0;
            r_tag_valid <= '0;
        end else if (w_allowin) begin
            r_ifd_valid <= ift_if.valid;
            if (ift_if.valid) begin
                {r_pc, r_warp_idx} <= ift_if.bus;
                r_tag_rdata        <= i_icache_tag_rdata;
                r_tag_valid        <= i_icache_tag_valid;
            end
        end
    end

    // Way compare; the lowest matching way wins
    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < L1_CACHE_NUM_WAYS; w++) begin
            w_hit_vec[w] = r_tag_valid[w] & (r_tag_rdata[w*TAG_WIDTH +: TAG_WIDTH] == w_pc_tag);
        end
        for (int w = L1_CACHE_NUM_WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit_way = WAYS_LOG'(w);
            end else begin
                w_hit_way = w_hit_way;
            end
        end
        w_hit = |w_hit_vec;
    end

    // Hit path toward decode and the data array
    always_comb begin
        w_id_valid  = 1'b0;
        w_id_bus    = '0;
        w_data_en   = 1'b0;
        w_data_addr = '0;
        if (w_eval && w_hit) begin
            w_id_valid  = 1'b1;
            w_id_bus    = {r_pc, r_warp_idx, w_hit_way};
            w_data_en   = 1'b1;
            w_data_addr = {w_set, w_hit_way, r_pc[LINE_LOG-1:2]};
        end else begin
            w_id_valid  = 1'b0;
            w_data_en   = 1'b0;
        end
    end

    // Miss classification: a line already being filled, or no room, means retry
    always_comb begin
        w_cache_miss = 1'b0;
        w_near_miss  = 1'b0;
        w_miss_warp  = '0;
        if (w_eval && !w_hit) begin
            if (w_fill_match || w_fifo_block) begin
                w_near_miss = 1'b1;
            end else begin
                w_cache_miss = 1'b1;
            end
            w_miss_warp = r_warp_idx;
        end else begin
            w_cache_miss = 1'b0;
            w_near_miss  = 1'b0;
        end
    end

    // Miss FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < MISS_FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_warp[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= {r_pc[ADDR_WIDTH-1:LINE_LOG], {LINE_LOG{1'b0}}};
                r_fifo_warp[r_wr_ptr] <= r_warp_idx;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IFD_PERF_COUNTER_EN
    logic [31:0] r_perf_hit_cnt;
    logic [31:0] r_perf_miss_cnt;

    // Event counters, free-running and wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_hit_cnt  <= 32'd0;
            r_perf_miss_cnt <= 32'd0;
        end else begin
            if (w_id_valid) begin
                r_perf_hit_cnt <= r_perf_hit_cnt + 32'd1;
            end
            if (w_cache_miss) begin
                r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
            end
        end
    end

    assign o_perf_hit_cnt  = r_perf_hit_cnt;
    assign o_perf_miss_cnt = r_perf_miss_cnt;
`endif

    assign ift_if.allowin              = w_allowin;
    assign id_if.valid                 = w_id_valid;
    assign id_if.bus                   = w_id_bus;
    assign o_ifd_to_icache_data_en     = w_data_en;
    assign o_ifd_to_icache_data_addr   = w_data_addr;
    assign o_ifd_cache_miss            = w_cache_miss;
    assign o_ifd_near_miss             = w_near_miss;
    assign o_ifd_cache_miss_warp_idx   = w_miss_warp;
    assign o_ifd_to_l2i_miss_valid     = w_fifo_valid;
    assign o_ifd_to_l2i_miss_addr      = w_fifo_valid ? r_fifo_addr[r_rd_ptr] : {ADDR_WIDTH{1'b0}};
    assign o_ifd_to_l2i_miss_warp_idx  = w_fifo_valid ? r_fifo_warp[r_rd_ptr] : {NUM_WARP_PER_CORE_LOG{1'b0}};

    ifetch_data_stage_chk #(.WAYS(L1_CACHE_NUM_WAYS)) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (r_ifd_valid),
        .i_hit_vec    (w_hit_vec),
        .i_cache_miss (w_cache_miss),
        .i_near_miss  (w_near_miss)
    );
endmodule
